// File: rtl/csr_file_timer.sv
// csr_file_timer: privileged CSR file with exception/ertn state, a countdown
// timer that raises ESTAT.IS[11], and a free-running 64-bit stable counter.
module csr_file_timer #(
    parameter int unsigned TIMER_W = 32,
    parameter int unsigned HWI_NUM = 8,
    parameter logic [31:0] TID_RST = 32'h0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               csr_we,
    input  logic [13:0]        csr_num,
    input  logic [31:0]        csr_wmask,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    input  logic               excp_flush,
    input  logic               ertn_flush,
    input  logic [5:0]         ecode,
    input  logic [8:0]         esubcode,
    input  logic [31:0]        epc,
    input  logic               badv_we,
    input  logic [31:0]        badv_value,
    input  logic [HWI_NUM-1:0] hw_int,
    input  logic               ipi_int,
    output logic [31:0]        era,
    output logic [31:0]        eentry,
    output logic               has_int,
    output logic [63:0]        stable_cnt,
    output logic [31:0]        counter_id
);
    localparam logic [13:0] ADDR_CRMD   = 14'h000;
    localparam logic [13:0] ADDR_PRMD   = 14'h001;
    localparam logic [13:0] ADDR_ECFG   = 14'h004;
    localparam logic [13:0] ADDR_ESTAT  = 14'h005;
    localparam logic [13:0] ADDR_ERA    = 14'h006;
    localparam logic [13:0] ADDR_BADV   = 14'h007;
    localparam logic [13:0] ADDR_EENTRY = 14'h00c;
    localparam logic [13:0] ADDR_SAVE0  = 14'h030;
    localparam logic [13:0] ADDR_SAVE1  = 14'h031;
    localparam logic [13:0] ADDR_SAVE2  = 14'h032;
    localparam logic [13:0] ADDR_SAVE3  = 14'h033;
    localparam logic [13:0] ADDR_TID    = 14'h040;
    localparam logic [13:0] ADDR_TCFG   = 14'h041;
    localparam logic [13:0] ADDR_TVAL   = 14'h042;
    localparam logic [13:0] ADDR_TICLR  = 14'h044;

    logic [8:0]         crmd;
    logic [2:0]         prmd;
    logic [12:0]        ecfg_lie;
    logic [1:0]         is_sw;
    logic [HWI_NUM-1:0] is_hw;
    logic               is_timer;
    logic               is_ipi;
    logic [5:0]         estat_ecode;
    logic [8:0]         estat_esubcode;
    logic [31:0]        era_q;
    logic [31:0]        badv;
    logic [25:0]        eentry_q;
    logic [31:0]        save [4];
    logic [31:0]        tid;
    logic [TIMER_W-1:0] tcfg;
    logic [TIMER_W-1:0] tval;
    logic [63:0]        cnt_q;

    logic [31:0] estat_word;
    logic [31:0] rd_raw;
    logic [31:0] merged;

    assign estat_word = {1'b0, estat_esubcode, estat_ecode, 3'b000, is_ipi, is_timer,
                         1'b0, 8'(is_hw), is_sw};

    always_comb begin
        rd_raw = '0;
        case (csr_num)
            ADDR_CRMD:   rd_raw = {23'b0, crmd};
            ADDR_PRMD:   rd_raw = {29'b0, prmd};
            ADDR_ECFG:   rd_raw = {19'b0, ecfg_lie};
            ADDR_ESTAT:  rd_raw = estat_word;
            ADDR_ERA:    rd_raw = era_q;
            ADDR_BADV:   rd_raw = badv;
            ADDR_EENTRY: rd_raw = {eentry_q, 6'b0};
            ADDR_SAVE0, ADDR_SAVE1, ADDR_SAVE2, ADDR_SAVE3:
                         rd_raw = save[csr_num[1:0]];
            ADDR_TID:    rd_raw = tid;
            ADDR_TCFG:   rd_raw = 32'(tcfg);
            ADDR_TVAL:   rd_raw = 32'(tval);
            default:     rd_raw = '0;
        endcase
    end

    // Every write targets the register being read, so one merged word serves all of them.
    assign merged = (csr_wdata & csr_wmask) | (rd_raw & ~csr_wmask);

    logic we_crmd, we_prmd, we_ecfg, we_estat, we_era, we_badv;
    logic we_eentry, we_save, we_tid, we_tcfg, ticlr_clr, timer_fire;

    assign we_crmd   = csr_we && csr_num == ADDR_CRMD && !excp_flush && !ertn_flush;
    assign we_prmd   = csr_we && csr_num == ADDR_PRMD && !excp_flush;
    assign we_ecfg   = csr_we && csr_num == ADDR_ECFG;
    assign we_estat  = csr_we && csr_num == ADDR_ESTAT && !excp_flush;
    assign we_era    = csr_we && csr_num == ADDR_ERA && !excp_flush;
    assign we_badv   = csr_we && csr_num == ADDR_BADV && !(excp_flush && badv_we);
    assign we_eentry = csr_we && csr_num == ADDR_EENTRY;
    assign we_save   = csr_we && csr_num[13:2] == ADDR_SAVE0[13:2];
    assign we_tid    = csr_we && csr_num == ADDR_TID;
    assign we_tcfg   = csr_we && csr_num == ADDR_TCFG;
    assign ticlr_clr = csr_we && csr_num == ADDR_TICLR && csr_wmask[0] && csr_wdata[0];
    assign timer_fire = !we_tcfg && tcfg[0] && tval == TIMER_W'(1);

    // NOTE: all state uses non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd <= 9'h008;
            prmd <= '0;
        end else if (excp_flush) begin
            prmd      <= crmd[2:0];
            crmd[2:0] <= 3'b000;
        end else begin
            if (ertn_flush)   crmd[2:0] <= prmd;
            else if (we_crmd) crmd      <= merged[8:0];
            if (we_prmd)      prmd      <= merged[2:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_sw          <= '0;
            is_hw          <= '0;
            is_timer       <= 1'b0;
            is_ipi         <= 1'b0;
            estat_ecode    <= '0;
            estat_esubcode <= '0;
        end else begin
            is_hw  <= hw_int;
            is_ipi <= ipi_int;
            if (timer_fire)     is_timer <= 1'b1;
            else if (ticlr_clr) is_timer <= 1'b0;
            if (excp_flush) begin
                estat_ecode    <= ecode;
                estat_esubcode <= esubcode;
            end else if (we_estat) begin
                is_sw <= merged[1:0];
            end
        end
    end

    // NOTE: the SAVE array is only four words, so it is reset like any other register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ecfg_lie <= '0;
            era_q    <= '0;
            badv     <= '0;
            eentry_q <= '0;
            tid      <= TID_RST;
            for (int i = 0; i < 4; i++) save[i] <= '0;
        end else begin
            if (we_ecfg)                   ecfg_lie <= merged[12:0] & 13'h1bff;
            if (excp_flush)                era_q    <= epc;
            else if (we_era)               era_q    <= merged;
            if (excp_flush && badv_we)     badv     <= badv_value;
            else if (we_badv)              badv     <= merged;
            if (we_eentry)                 eentry_q <= merged[31:6];
            if (we_save)                   save[csr_num[1:0]] <= merged;
            if (we_tid)                    tid      <= merged;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcfg <= '0;
            tval <= '0;
        end else if (we_tcfg) begin
            tcfg <= merged[TIMER_W-1:0];
            tval <= {merged[TIMER_W-1:2], 2'b00};
        end else if (tcfg[0] && tval != '0) begin
            tval <= tval - TIMER_W'(1);
        end else if (tcfg[0] && tcfg[1]) begin
            tval <= {tcfg[TIMER_W-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_q + 64'd1;
    end

    assign csr_rdata  = resetn ? rd_raw : 32'h0;
    assign era        = era_q;
    assign eentry     = {eentry_q, 6'b0};
    assign has_int    = crmd[2] && |(estat_word[12:0] & ecfg_lie);
    assign stable_cnt = cnt_q;
    assign counter_id = tid;
endmodule

// File: tb/tb_csr_file_timer.sv
// Self-checking bench for csr_file_timer: word-level reference model compared every
// cycle, plus directed sequences with hand-computed expectations.
module tb_csr_file_timer;
    localparam int unsigned TIMER_W = 16;
    localparam int unsigned HWI_NUM = 8;
    localparam logic [31:0] TID_RST = 32'h5a5a_0001;
    localparam logic [31:0] TMASK   = (TIMER_W >= 32) ? 32'hffff_ffff : ((32'd1 << TIMER_W) - 32'd1);

    localparam logic [13:0] A_CRMD = 14'h000, A_PRMD = 14'h001, A_ECFG = 14'h004;
    localparam logic [13:0] A_ESTAT = 14'h005, A_ERA = 14'h006, A_BADV = 14'h007;
    localparam logic [13:0] A_EENTRY = 14'h00c, A_SAVE2 = 14'h032, A_TID = 14'h040;
    localparam logic [13:0] A_TCFG = 14'h041, A_TVAL = 14'h042, A_TICLR = 14'h044;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               csr_we = 1'b0;
    logic [13:0]        csr_num = '0;
    logic [31:0]        csr_wmask = '0;
    logic [31:0]        csr_wdata = '0;
    logic [31:0]        csr_rdata;
    logic               excp_flush = 1'b0;
    logic               ertn_flush = 1'b0;
    logic [5:0]         ecode = '0;
    logic [8:0]         esubcode = '0;
    logic [31:0]        epc = '0;
    logic               badv_we = 1'b0;
    logic [31:0]        badv_value = '0;
    logic [HWI_NUM-1:0] hw_int = '0;
    logic               ipi_int = 1'b0;
    logic [31:0]        era;
    logic [31:0]        eentry;
    logic               has_int;
    logic [63:0]        stable_cnt;
    logic [31:0]        counter_id;

    int total = 0;
    int bad   = 0;

    csr_file_timer #(.TIMER_W(TIMER_W), .HWI_NUM(HWI_NUM), .TID_RST(TID_RST)) dut (
        .clk(clk), .resetn(resetn), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wmask(csr_wmask), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush), .ecode(ecode),
        .esubcode(esubcode), .epc(epc), .badv_we(badv_we), .badv_value(badv_value),
        .hw_int(hw_int), .ipi_int(ipi_int), .era(era), .eentry(eentry),
        .has_int(has_int), .stable_cnt(stable_cnt), .counter_id(counter_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: architectural register words ----------------
    typedef struct packed {
        logic [31:0]       crmd, prmd, ecfg, estat, era, badv, eentry;
        logic [3:0][31:0]  save;
        logic [31:0]       tid, tcfg, tval;
        logic [63:0]       cnt;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t reset_state();
        mstate_t r = '0;
        r.crmd = 32'h8;
        r.tid  = TID_RST;
        return r;
    endfunction

    function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] f);
        return (old & ~(csr_wmask & f)) | (csr_wdata & csr_wmask & f);
    endfunction

    function automatic logic [31:0] model_rd(input mstate_t s, input logic [13:0] num);
        case (num)
            A_CRMD:   return s.crmd;
            A_PRMD:   return s.prmd;
            A_ECFG:   return s.ecfg;
            A_ESTAT:  return s.estat;
            A_ERA:    return s.era;
            A_BADV:   return s.badv;
            A_EENTRY: return s.eentry;
            14'h030, 14'h031, 14'h032, 14'h033: return s.save[num[1:0]];
            A_TID:    return s.tid;
            A_TCFG:   return s.tcfg;
            A_TVAL:   return s.tval;
            default:  return 32'h0;
        endcase
    endfunction

    function automatic mstate_t next_state(input mstate_t s);
        mstate_t n = s;
        logic fire = 1'b0;
        logic tbit;
        n.cnt = s.cnt + 64'd1;
        if (csr_we && csr_num == A_TCFG) begin
            n.tcfg = mrg(s.tcfg, TMASK);
            n.tval = n.tcfg & ~32'h3;
        end else if (s.tcfg[0] && s.tval != 0) begin
            n.tval = s.tval - 32'd1;
            fire   = (s.tval == 32'd1);
        end else if (s.tcfg[0] && s.tcfg[1]) begin
            n.tval = s.tcfg & ~32'h3;
        end
        tbit = s.estat[11];
        if (csr_we && csr_num == A_TICLR && csr_wmask[0] && csr_wdata[0]) tbit = 1'b0;
        if (fire) tbit = 1'b1;
        n.estat = (s.estat & 32'hffff_e003) | (32'(ipi_int) << 12) | (32'(tbit) << 11)
                | (32'(hw_int) << 2);
        if (excp_flush) begin
            n.prmd  = s.crmd & 32'h7;
            n.crmd  = s.crmd & ~32'h7;
            n.estat = (n.estat & 32'h8000_ffff) | (32'(esubcode) << 22) | (32'(ecode) << 16);
            n.era   = epc;
            if (badv_we) n.badv = badv_value;
        end else if (ertn_flush) begin
            n.crmd = (s.crmd & ~32'h7) | (s.prmd & 32'h7);
        end
        if (csr_we) begin
            case (csr_num)
                A_CRMD:   if (!excp_flush && !ertn_flush) n.crmd = mrg(s.crmd, 32'h1ff);
                A_PRMD:   if (!excp_flush) n.prmd = mrg(s.prmd, 32'h7);
                A_ECFG:   n.ecfg = mrg(s.ecfg, 32'h1bff);
                A_ESTAT:  if (!excp_flush) n.estat = (n.estat & ~32'h3) | (mrg(s.estat, 32'h3) & 32'h3);
                A_ERA:    if (!excp_flush) n.era = mrg(s.era, 32'hffff_ffff);
                A_BADV:   if (!(excp_flush && badv_we)) n.badv = mrg(s.badv, 32'hffff_ffff);
                A_EENTRY: n.eentry = mrg(s.eentry, 32'hffff_ffc0);
                14'h030, 14'h031, 14'h032, 14'h033:
                          n.save[csr_num[1:0]] = mrg(s.save[csr_num[1:0]], 32'hffff_ffff);
                A_TID:    n.tid = mrg(s.tid, 32'hffff_ffff);
                default:  ;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) m <= reset_state();
        else         m <= next_state(m);
    end

    // ---------------- per-cycle comparison against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                check("rst_rdata", 64'(csr_rdata), 64'h0);
                check("rst_era", 64'(era), 64'h0);
                check("rst_eentry", 64'(eentry), 64'h0);
                check("rst_has_int", 64'(has_int), 64'h0);
                check("rst_stable_cnt", stable_cnt, 64'h0);
                check("rst_counter_id", 64'(counter_id), 64'(TID_RST));
            end else begin
                check("cmp_rdata", 64'(csr_rdata), 64'(model_rd(m, csr_num)));
                check("cmp_era", 64'(era), 64'(m.era));
                check("cmp_eentry", 64'(eentry), 64'(m.eentry));
                check("cmp_has_int", 64'(has_int),
                      64'(m.crmd[2] & |(m.estat[12:0] & m.ecfg[12:0])));
                check("cmp_stable_cnt", stable_cnt, m.cnt);
                check("cmp_counter_id", 64'(counter_id), 64'(m.tid));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] d, input logic [31:0] mk);
        csr_num = num; csr_wdata = d; csr_wmask = mk; csr_we = 1'b1;
        tick();
        csr_we = 1'b0; csr_wdata = '0; csr_wmask = '0;
    endtask

    task automatic rd(input logic [13:0] num, output logic [31:0] val);
        csr_num = num;
        #1;
        val = csr_rdata;
    endtask

    task automatic rd_chk(input string name, input logic [13:0] num, input logic [31:0] exp);
        logic [31:0] v;
        rd(num, v);
        check(name, 64'(v), 64'(exp));
    endtask

    logic [31:0] v;
    int          per_tval [10] = '{3, 2, 1, 0, 4, 3, 2, 1, 0, 4};
    logic        per_is   [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    logic        per_clr  [10] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0};

    initial begin
        repeat (3) tick();
        resetn = 1'b1;
        rd_chk("reset_crmd", A_CRMD, 32'h8);
        rd_chk("reset_tval", A_TVAL, 32'h0);
        rd_chk("reset_tid", A_TID, TID_RST);
        check("reset_stable_cnt", stable_cnt, 64'd0);
        check("reset_has_int", 64'(has_int), 64'd0);
        tick();
        check("stable_cnt_first", stable_cnt, 64'd1);

        // reset in the middle of a countdown
        wr(A_TCFG, 32'h101, 32'hffff_ffff);
        repeat (5) tick();
        rd_chk("midcount_tval", A_TVAL, 32'hfb);
        resetn = 1'b0;
        #1;
        check("async_rst_cnt", stable_cnt, 64'd0);
        check("async_rst_id", 64'(counter_id), 64'(TID_RST));
        repeat (2) tick();
        resetn = 1'b1;
        rd_chk("rerelease_tval", A_TVAL, 32'h0);
        rd_chk("rerelease_crmd", A_CRMD, 32'h8);
        rd_chk("rerelease_tcfg", A_TCFG, 32'h0);

        // masked writes and flush priority
        wr(A_CRMD, 32'h7, 32'h4);
        rd_chk("crmd_masked", A_CRMD, 32'hc);
        wr(A_CRMD, 32'h6, 32'h3);
        rd_chk("crmd_plv2_ie", A_CRMD, 32'he);
        excp_flush = 1'b1; epc = 32'h100;
        wr(A_CRMD, 32'h1f0, 32'h1f0);
        excp_flush = 1'b0; epc = '0;
        rd_chk("crmd_write_dropped", A_CRMD, 32'h8);
        rd_chk("prmd_captured", A_PRMD, 32'h6);
        rd_chk("era_plain_excp", A_ERA, 32'h100);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        rd_chk("ertn_restore", A_CRMD, 32'he);

        // exception with BADV capture, then ertn
        excp_flush = 1'b1; ecode = 6'h8; esubcode = 9'h1; epc = 32'h1c00_0100;
        badv_we = 1'b1; badv_value = 32'hdead;
        tick();
        excp_flush = 1'b0; ecode = '0; esubcode = '0; epc = '0; badv_we = 1'b0; badv_value = '0;
        rd_chk("excp_estat", A_ESTAT, 32'h0048_0000);
        rd_chk("excp_era", A_ERA, 32'h1c00_0100);
        rd_chk("excp_badv", A_BADV, 32'hdead);
        check("excp_era_port", 64'(era), 64'h1c00_0100);
        tick();
        rd_chk("excp_crmd", A_CRMD, 32'h8);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        rd_chk("ertn_crmd", A_CRMD, 32'he);

        // field restrictions and unmapped space
        wr(14'h002, 32'hffff_ffff, 32'hffff_ffff);
        rd_chk("unmapped_reads_0", 14'h002, 32'h0);
        wr(A_SAVE2, 32'h1234_5678, 32'hffff_0000);
        rd_chk("save2_masked", A_SAVE2, 32'h1234_0000);
        wr(A_EENTRY, 32'hffff_ffff, 32'hffff_ffff);
        check("eentry_port", 64'(eentry), 64'hffff_ffc0);
        wr(A_ESTAT, 32'hffff_ffff, 32'hffff_ffff);
        rd_chk("estat_sw_only", A_ESTAT, 32'h0048_0003);
        wr(A_ESTAT, 32'h0, 32'h3);
        wr(A_TCFG, 32'hffff_fff0, 32'hffff_ffff);
        rd_chk("tcfg_width", A_TCFG, 32'hfff0);
        rd_chk("tval_load", A_TVAL, 32'hfff0);
        rd_chk("ticlr_reads_0", A_TICLR, 32'h0);
        tick();
        rd_chk("tval_hold_disabled", A_TVAL, 32'hfff0);

        // one-shot countdown
        wr(A_TCFG, 32'h9, 32'hffff_ffff);
        rd_chk("oneshot_load", A_TVAL, 32'h8);
        for (int i = 7; i >= 0; i--) begin
            tick();
            rd_chk("oneshot_tval", A_TVAL, 32'(i));
            rd(A_ESTAT, v);
            check("oneshot_is11", 64'(v[11]), 64'(i == 0));
        end
        repeat (3) tick();
        rd_chk("oneshot_stays_0", A_TVAL, 32'h0);
        wr(A_ECFG, 32'h800, 32'h800);
        check("timer_has_int", 64'(has_int), 64'd1);
        wr(A_TICLR, 32'h1, 32'h1);
        rd(A_ESTAT, v);
        check("ticlr_clears", 64'(v[11]), 64'd0);
        check("ticlr_has_int", 64'(has_int), 64'd0);

        // periodic with TICLR racing the 1->0 edge
        wr(A_TCFG, 32'h7, 32'hffff_ffff);
        rd_chk("periodic_load", A_TVAL, 32'h4);
        for (int i = 0; i < 10; i++) begin
            if (per_clr[i]) wr(A_TICLR, 32'h1, 32'h1);
            else            tick();
            rd_chk("periodic_tval", A_TVAL, 32'(per_tval[i]));
            rd(A_ESTAT, v);
            check("periodic_is11", 64'(v[11]), 64'(per_is[i]));
        end
        wr(A_TCFG, 32'h0, 32'hffff_ffff);
        wr(A_TICLR, 32'h1, 32'h1);

        // hardware and IPI interrupt latency
        wr(A_ECFG, 32'h20, 32'h20);
        hw_int = 8'h08;
        #1;
        check("hwi_not_yet", 64'(has_int), 64'd0);
        tick();
        check("hwi_one_cycle", 64'(has_int), 64'd1);
        rd(A_ESTAT, v);
        check("hwi_estat_bit5", 64'(v[5]), 64'd1);
        hw_int = '0;
        tick();
        check("hwi_drop", 64'(has_int), 64'd0);
        wr(A_ECFG, 32'hffff_ffff, 32'hffff_ffff);
        rd_chk("ecfg_lie_mask", A_ECFG, 32'h1bff);
        ipi_int = 1'b1;
        tick();
        rd(A_ESTAT, v);
        check("ipi_estat_bit12", 64'(v[12]), 64'd1);
        check("ipi_has_int", 64'(has_int), 64'd1);
        ipi_int = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/csr_file_timer.md
Name: csr_file_timer

Overview:
- Parametrised successor to the core CSR file: holds CRMD/PRMD/ECFG/ESTAT/ERA/BADV/EENTRY/SAVE0-3 plus a working TID/TCFG/TVAL/TICLR timer block and a free-running 64-bit stable counter.
- Sits beside the writeback stage. Takes CSR read/write, exception and ertn commit events. Returns read data, ERA/EENTRY and the registered interrupt-pending flag to the pipeline.

Parameters:
TIMER_W, 32, width of TVAL and TCFG.InitVal+2 (legal 8..32; TCFG bits above TIMER_W-1 read 0)
HWI_NUM, 8, hardware interrupt lines sampled into ESTAT.IS[HWI_NUM+1:2] (legal 1..8; unused IS bits read 0)
TID_RST, 32'h0, reset value of TID

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
csr_we  in  1  CSR write strobe (committed instruction)
csr_num  in  14  CSR address for read and write
csr_wmask  in  32  per-bit write mask
csr_wdata  in  32  write data
csr_rdata  out  32  combinational read data for csr_num
excp_flush  in  1  exception commit
ertn_flush  in  1  ertn commit
ecode  in  6  exception code
esubcode  in  9  exception subcode
epc  in  32  PC of excepting instruction
badv_we  in  1  with excp_flush: capture badv_value
badv_value  in  32  faulting address
hw_int  in  HWI_NUM  level hardware interrupts
ipi_int  in  1  inter-processor interrupt level
era  out  32  ERA contents
eentry  out  32  EENTRY contents
has_int  out  1  interrupt pending and enabled
stable_cnt  out  64  stable counter value
counter_id  out  32  equals TID

Behaviour:
- Reset: asynchronous on resetn low, all state cleared except CRMD.DA=1 and TID=TID_RST. All outputs are 0 during reset, except counter_id=TID_RST.
- Addresses: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44. Unmapped addresses read 0 and ignore writes.
- Reads are combinational from the current registers. A write becomes visible from the next cycle.
- Every masked write is new = wmask&wdata | ~wmask&old, restricted to writable fields.
- Writable fields: CRMD[8:0]; PRMD[2:0]; ECFG.LIE bits {12,11,9:0}; ESTAT.IS[1:0]; ERA, BADV, SAVEx, TID full width; EENTRY[31:6]; TCFG[TIMER_W-1:0]. TVAL is read-only.
- Priority per cycle: excp_flush > ertn_flush > csr_we. A write to a register that the same cycle's flush updates is dropped.
- excp_flush:
  - PRMD.PPLV/PIE <= CRMD.PLV/IE; CRMD.PLV/IE <= 0.
  - ESTAT.Ecode[21:16] <= ecode; ESTAT.EsubCode[30:22] <= esubcode; ERA <= epc.
  - If badv_we, BADV <= badv_value.
- ertn_flush: CRMD.PLV/IE <= PRMD.PPLV/PIE.
- ESTAT.IS sampling: IS[HWI_NUM+1:2] <= hw_int and IS[12] <= ipi_int every cycle, so one cycle of latency. IS[10] is always 0.
- Timer, TCFG fields: En=bit0, Periodic=bit1, InitVal=[TIMER_W-1:2].
  - TCFG write: TVAL <= {new InitVal, 2'b00}. This overrides counting in that cycle.
  - Else if En and TVAL!=0: TVAL <= TVAL-1. The 1->0 transition sets IS[11] on the same edge.
  - Else if En and TVAL==0 and Periodic: TVAL <= {InitVal, 2'b00}.
  - Else, one-shot expired or En=0: TVAL holds.
  - TVAL reads zero-extended to 32 bits.
- TICLR: a write with wmask[0]&wdata[0] clears IS[11]. If the timer sets IS[11] in the same cycle, set wins. TICLR always reads 0.
- has_int is combinational from registers: CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).
- stable_cnt increments every cycle from 0 and wraps 2^64-1 -> 0. counter_id = TID.

Test Plan:
- Reset: hold resetn low mid-count, then release -> CRMD reads 0x8, TVAL=0, stable_cnt=0, has_int=0. TID reads TID_RST.
- Masked write: CRMD=0x8, write CRMD wdata=0x7 wmask=0x4 -> reads 0xC. The same write with excp_flush asserted is dropped; CRMD.PLV/IE=0 and PRMD captures the old values.
- One-shot timer: write TCFG=0x9 (InitVal=2, En) -> TVAL reads 8, then counts down 7..0. IS[11] is set on the edge TVAL reaches 0. TVAL stays 0. With ECFG.LIE[11]=1 and CRMD.IE=1, has_int=1.
- Periodic: TCFG=0x7 (InitVal=1, Per, En) -> TVAL sequence 4,3,2,1,0,4,3…; IS[11] is re-set every wrap. TICLR write 1 in the same cycle as the 1->0 edge leaves IS[11]=1.
- Interrupt latency: raise hw_int[3] with LIE[5]=1 and IE=1 -> has_int rises exactly one cycle later. ESTAT bit 5 reads 1.
- Exception/ertn: excp_flush with ecode=0x8, esubcode=0x1, epc=0x1c000100, badv_we=1, badv=0xdead -> ESTAT[30:16]=0x0048, ERA=0x1c000100, BADV=0xdead. ertn_flush then restores CRMD.PLV/IE from PRMD.
